// File: rtl/pwm_bus_dist.sv
// PWM command bus fan-out to per-submodule A/B gate drives, with per-leg
// dead-time insertion, A/B overlap blocking, global enable and latched fault shutdown.
module pwm_bus_dist #(
  parameter int N_PH = 3,
  parameter int N_SM = 24,
  parameter int DT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PH*N_SM*2-1:0]   pwm_bus,
  input  logic [DT_W-1:0]          dt_cyc,
  input  logic                     en,
  input  logic                     fault_in,
  input  logic                     fault_clr,
  output logic [N_PH*N_SM*2-1:0]   gate_out,
  output logic                     fault_latched,
  output logic [N_PH-1:0]          ovl_err
);

  localparam int N_LEG = N_PH * N_SM;
  localparam int BW    = 2 * N_LEG;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DT_A = 3'd1;
  localparam logic [2:0] ST_A_ON = 3'd2;
  localparam logic [2:0] ST_DT_B = 3'd3;
  localparam logic [2:0] ST_B_ON = 3'd4;

  localparam logic [DT_W-1:0] CNT_ZERO = {DT_W{1'b0}};
  localparam logic [DT_W-1:0] CNT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};

  logic [BW-1:0]   cmd_q;
  logic            fault_in_q;
  logic            fault_q;
  logic            fault_d;
  logic [N_PH-1:0] ovl_q;
  logic [N_PH-1:0] ovl_d;
  logic [N_PH-1:0] ovl_hit_s;
  logic            clr_ok_s;
  logic            force_idle_s;

  // A registered fault holds every leg idle on the same edge the latch sets.
  assign force_idle_s = ~en | fault_in_q | fault_q;
  assign clr_ok_s     = fault_clr & ~fault_in;

  // Sticky fault and per-phase overlap status; a new set always beats a clear.
  always_comb begin
    fault_d = fault_in_q | (fault_q & ~clr_ok_s);
    for (int p = 0; p < N_PH; p++) begin
      ovl_hit_s[p] = 1'b0;
      for (int j = 0; j < N_SM; j++) begin
        ovl_hit_s[p] = ovl_hit_s[p] |
                       (cmd_q[2*(p*N_SM+j)+1] & cmd_q[2*(p*N_SM+j)]);
      end
      ovl_d[p] = ovl_hit_s[p] | (ovl_q[p] & ~clr_ok_s);
    end
  end

  // Input register and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= {BW{1'b0}};
      fault_in_q <= 1'b0;
      fault_q    <= 1'b0;
      ovl_q      <= {N_PH{1'b0}};
    end else begin
      cmd_q      <= pwm_bus;
      fault_in_q <= fault_in;
      fault_q    <= fault_d;
      ovl_q      <= ovl_d;
    end
  end

  assign fault_latched = fault_q;
  assign ovl_err       = ovl_q;

  // Leg l owns bits [2l+1:2l] (A high, B low), which matches the SM packing.
  for (genvar l = 0; l < N_LEG; l++) begin : g_leg
    logic [2:0]      st_q;
    logic [2:0]      st_d;
    logic [DT_W-1:0] cnt_q;
    logic [DT_W-1:0] cnt_d;
    logic            ga_q;
    logic            ga_d;
    logic            gb_q;
    logic            gb_d;
    logic [1:0]      cmd_s;

    assign cmd_s = cmd_q[2*l+1:2*l];

    // Leg next-state: every exit from a dead-time or ON state passes through IDLE.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (force_idle_s || (cmd_s == 2'b11)) begin
        st_d  = ST_IDLE;
        cnt_d = CNT_ZERO;
      end else begin
        case (st_q)
          ST_IDLE: begin
            if (cmd_s == 2'b10) begin
              if (dt_cyc == CNT_ZERO) begin
                st_d = ST_A_ON;
              end else begin
                st_d  = ST_DT_A;
                cnt_d = dt_cyc;
              end
            end else if (cmd_s == 2'b01) begin
              if (dt_cyc == CNT_ZERO) begin
                st_d = ST_B_ON;
              end else begin
                st_d  = ST_DT_B;
                cnt_d = dt_cyc;
              end
            end else begin
              st_d = ST_IDLE;
            end
          end
          ST_DT_A: begin
            if (cmd_s != 2'b10) begin
              st_d  = ST_IDLE;
              cnt_d = CNT_ZERO;
            end else if (cnt_q == CNT_ONE) begin
              st_d  = ST_A_ON;
              cnt_d = CNT_ZERO;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_DT_B: begin
            if (cmd_s != 2'b01) begin
              st_d  = ST_IDLE;
              cnt_d = CNT_ZERO;
            end else if (cnt_q == CNT_ONE) begin
              st_d  = ST_B_ON;
              cnt_d = CNT_ZERO;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_A_ON: begin
            if (cmd_s != 2'b10) begin
              st_d = ST_IDLE;
            end else begin
              st_d = ST_A_ON;
            end
          end
          ST_B_ON: begin
            if (cmd_s != 2'b01) begin
              st_d = ST_IDLE;
            end else begin
              st_d = ST_B_ON;
            end
          end
          default: begin
            st_d  = ST_IDLE;
            cnt_d = CNT_ZERO;
          end
        endcase
      end
      ga_d = (st_d == ST_A_ON);
      gb_d = (st_d == ST_B_ON);
    end

    // Leg state and gate flops; gates come from next-state, never decoded from st_q.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= ST_IDLE;
        cnt_q <= CNT_ZERO;
        ga_q  <= 1'b0;
        gb_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        ga_q  <= ga_d;
        gb_q  <= gb_d;
      end
    end

    assign gate_out[2*l+1] = ga_q;
    assign gate_out[2*l]   = gb_q;
  end

endmodule

// File: tb/tb_pwm_bus_dist.sv
// Bench for pwm_bus_dist: directed latency/fault/overlap steps plus random traffic,
// all checked against a timestamp-based reference model of the gate rules.
module tb_pwm_bus_dist;
  localparam int N_PH = 3;
  localparam int N_SM = 24;
  localparam int DT_W = 8;
  localparam int N_LEG = N_PH * N_SM;
  localparam int BW = 2 * N_LEG;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [BW-1:0]   pwm_bus;
  logic [DT_W-1:0] dt_cyc;
  logic            en;
  logic            fault_in;
  logic            fault_clr;
  logic [BW-1:0]   gate_out;
  logic            fault_latched;
  logic [N_PH-1:0] ovl_err;

  pwm_bus_dist #(.N_PH(N_PH), .N_SM(N_SM), .DT_W(DT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_bus(pwm_bus), .dt_cyc(dt_cyc), .en(en),
    .fault_in(fault_in), .fault_clr(fault_clr), .gate_out(gate_out),
    .fault_latched(fault_latched), .ovl_err(ovl_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: each leg has a requested side (0 none, 1 A, 2 B), the edge the
  // request began and the dead-time captured then; the gate is on once that long elapsed.
  logic [BW-1:0]   cmdq_m;
  logic            fq_m;
  logic            fl_m;
  logic [N_PH-1:0] ovl_m;
  logic [BW-1:0]   exp_gate;
  int side_m [N_LEG];
  int start_m [N_LEG];
  int dlat_m [N_LEG];
  int edge_n = 0;

  function automatic int abit(input int p, input int k);
    return p*2*N_SM + 2*N_SM - 2*k + 1;
  endfunction

  task automatic chkv(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chko(input string tag, input logic [N_PH-1:0] obs, input logic [N_PH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    cmdq_m = '0; fq_m = 1'b0; fl_m = 1'b0; ovl_m = '0; exp_gate = '0;
    for (int l = 0; l < N_LEG; l++) begin
      side_m[l] = 0; start_m[l] = 0; dlat_m[l] = 0;
    end
  endtask

  task automatic model_edge();
    logic force_s;
    logic clr_s;
    logic [N_PH-1:0] hit;
    logic [1:0] c;
    int eff;
    force_s = !en || fq_m || fl_m;
    hit = '0;
    for (int l = 0; l < N_LEG; l++) begin
      c = {cmdq_m[2*l+1], cmdq_m[2*l]};
      if (c == 2'b11) hit[l / N_SM] = 1'b1;
      if (force_s) eff = 0;
      else if (c == 2'b10) eff = 1;
      else if (c == 2'b01) eff = 2;
      else eff = 0;
      if (side_m[l] != 0) begin
        if (eff != side_m[l]) side_m[l] = 0;
      end else if (eff != 0) begin
        side_m[l] = eff; start_m[l] = edge_n; dlat_m[l] = int'(dt_cyc);
      end
      exp_gate[2*l+1] = (side_m[l] == 1) && (edge_n - start_m[l] >= dlat_m[l]);
      exp_gate[2*l]   = (side_m[l] == 2) && (edge_n - start_m[l] >= dlat_m[l]);
    end
    clr_s = fault_clr && !fault_in;
    fl_m = fq_m || (fl_m && !clr_s);
    ovl_m = hit | (ovl_m & {N_PH{!clr_s}});
    fq_m = fault_in;
    cmdq_m = pwm_bus;
  endtask

  task automatic step();
    logic pair_bad;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    chkv("gate_model", gate_out, exp_gate);
    chkb("fault_model", fault_latched, fl_m);
    chko("ovl_model", ovl_err, ovl_m);
    pair_bad = |(gate_out & (gate_out >> 1) & {N_LEG{2'b01}});
    chkb("ab_both_high", pair_bad, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] all_a;
    logic [BW-1:0] all_b;
    int a, b;
    all_a = {N_LEG{2'b10}};
    all_b = {N_LEG{2'b01}};
    rst_n = 1'b0; pwm_bus = '0; dt_cyc = 8'd3; en = 1'b1; fault_in = 1'b0; fault_clr = 1'b0;
    reset_model();
    #3;
    chkv("rst_gate", gate_out, {BW{1'b0}});
    chkb("rst_fault", fault_latched, 1'b0);
    chko("rst_ovl", ovl_err, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // D=3 on phase 0 SM1: rise at edge 5; A->B gap of 4 cycles
    a = abit(0, 1); b = a - 1;
    pwm_bus[a] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(); chkb("d3_rise_a", gate_out[a], e >= 5);
    end
    pwm_bus[a] = 1'b0; pwm_bus[b] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(); chkb("d3_sw_a", gate_out[a], e < 2); chkb("d3_sw_b", gate_out[b], e >= 6);
    end

    // D=0: B->A with exactly one cycle both low
    dt_cyc = 8'd0;
    pwm_bus[b] = 1'b0; pwm_bus[a] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step(); chkb("d0_sw_b", gate_out[b], e < 2); chkb("d0_sw_a", gate_out[a], e >= 3);
    end

    // D=255: full count, rise at edge 257
    pwm_bus = '0;
    repeat (3) step();
    dt_cyc = 8'd255;
    pwm_bus[a] = 1'b1;
    for (int e = 1; e <= 258; e++) begin
      step();
      if (e >= 256) chkb("d255_rise", gate_out[a], e >= 257);
    end

    // Overlap on phase 2 SM24
    pwm_bus = '0; dt_cyc = 8'd2;
    repeat (3) step();
    a = abit(2, 24); b = a - 1;
    pwm_bus[a] = 1'b1; pwm_bus[b] = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chkb("ovl_gate_a", gate_out[a], 1'b0);
      chkb("ovl_gate_b", gate_out[b], 1'b0);
      chko("ovl_flag", ovl_err, (e >= 2) ? 3'b100 : 3'b000);
    end
    pwm_bus = '0;
    repeat (2) step();
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    chko("ovl_clear", ovl_err, 3'b000);

    // Fault shutdown with all legs on
    pwm_bus = all_a;
    repeat (5) step();
    chkv("all_on", gate_out, all_a);
    fault_in = 1'b1; step(); fault_in = 1'b0;
    step();
    chkv("fault_gate_off", gate_out, {BW{1'b0}});
    chkb("fault_set", fault_latched, 1'b1);
    repeat (4) step();
    chkv("fault_hold", gate_out, {BW{1'b0}});
    fault_in = 1'b1; fault_clr = 1'b1; step(); fault_in = 1'b0; fault_clr = 1'b0;
    repeat (2) step();
    chkb("clr_ignored", fault_latched, 1'b1);
    fault_clr = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step(); fault_clr = 1'b0;
      chkb("clr_fault", fault_latched, 1'b0);
      chkv("clr_rise", gate_out, (e >= 4) ? all_a : {BW{1'b0}});
    end

    // en dropped mid dead-time on phase 1 SM3, D=5
    pwm_bus = '0;
    repeat (3) step();
    dt_cyc = 8'd5;
    a = abit(1, 3);
    pwm_bus[a] = 1'b1;
    repeat (3) step();
    en = 1'b0; step(); en = 1'b1;
    chkb("en_low", gate_out[a], 1'b0);
    for (int e = 1; e <= 7; e++) begin
      step(); chkb("en_redt", gate_out[a], e >= 6);
    end

    // Random traffic across all 72 legs
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int l = 0; l < N_LEG; l++) begin
        int r;
        r = $urandom_range(0, 63);
        if (r == 0) begin
          int s;
          s = $urandom_range(0, 2);
          pwm_bus[2*l+1] = (s == 1);
          pwm_bus[2*l]   = (s == 2);
        end else if (r == 1 && $urandom_range(0, 7) == 0) begin
          pwm_bus[2*l+1] = 1'b1; pwm_bus[2*l] = 1'b1;
        end
      end
      en = ($urandom_range(0, 79) != 0);
      fault_in = ($urandom_range(0, 199) == 0);
      fault_clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) dt_cyc = 8'($urandom_range(0, 4));
      step();
    end
    fault_in = 1'b0; fault_clr = 1'b0; en = 1'b1;
    step();
    fault_clr = 1'b1; step(); fault_clr = 1'b0;

    // Async reset in B_ON, then restart from IDLE
    pwm_bus = all_b; dt_cyc = 8'd1;
    repeat (6) step();
    chkv("all_b_on", gate_out, all_b);
    #3 rst_n = 1'b0;
    #1;
    chkv("async_rst_gate", gate_out, {BW{1'b0}});
    chkb("async_rst_fault", fault_latched, 1'b0);
    chko("async_rst_ovl", ovl_err, 3'b000);
    reset_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step(); chkv("restart_b", gate_out, (e >= 3) ? all_b : {BW{1'b0}});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
